// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the registered instruction ROM and
// hands instructions to the control unit over valid/ready. Optional: FETCH_PREFETCH_EN.
module fetch_unit #(
    parameter int               ADDR_W  = 11,
    parameter int               INSTR_W = 17,
    parameter int               OP_W    = 5,
    parameter logic [OP_W-1:0]  ENDOP   = 5'd31
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    output logic [INSTR_W-1:0] ir_out,
    output logic               ir_valid,
    input  logic               ir_ready,
    input  logic               jump_en,
    input  logic [ADDR_W-1:0]  jump_target,
    output logic [ADDR_W-1:0]  pc_out,
    output logic               halted
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_CAP   = 3'd2,
        S_VALID = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  pc, pc_nxt, pc_inc;
    logic [INSTR_W-1:0] ir_nxt;
    logic [ADDR_W-1:0]  pc_out_nxt;
    logic               ir_valid_nxt;
    logic               halted_nxt;
    logic               handshake;
    logic               is_endop;

    assign pc_inc    = pc + ADDR_W'(1);
    assign handshake = ir_valid && ir_ready;
    assign is_endop  = (ir_out[INSTR_W-1 -: OP_W] == ENDOP);

`ifdef FETCH_PREFETCH_EN
    // While an instruction waits in VALID, the ROM speculatively reads the next word.
    assign imem_addr = (state == S_VALID) ? pc_inc : pc;
`else
    assign imem_addr = pc;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            pc       <= '0;
            ir_out   <= '0;
            pc_out   <= '0;
            ir_valid <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= state_nxt;
            pc       <= pc_nxt;
            ir_out   <= ir_nxt;
            pc_out   <= pc_out_nxt;
            ir_valid <= ir_valid_nxt;
            halted   <= halted_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        ir_nxt       = ir_out;
        pc_out_nxt   = pc_out;
        ir_valid_nxt = ir_valid;
        halted_nxt   = halted;

        unique case (state)
            S_IDLE: begin
                if (start) begin
                    pc_nxt    = '0;
                    state_nxt = S_REQ;
                end
            end

            // ROM registers imem_addr on this edge; its data is usable in CAP.
            S_REQ: begin
                state_nxt = S_CAP;
            end

            S_CAP: begin
                ir_nxt       = imem_data;
                pc_out_nxt   = pc;
                ir_valid_nxt = 1'b1;
                state_nxt    = S_VALID;
            end

            S_VALID: begin
                if (handshake) begin
                    ir_valid_nxt = 1'b0;
                    if (is_endop) begin
                        halted_nxt = 1'b1;
                        state_nxt  = S_HALT;
                    end else if (jump_en) begin
                        pc_nxt    = jump_target;
                        state_nxt = S_REQ;
                    end else begin
                        pc_nxt    = pc_inc;
`ifdef FETCH_PREFETCH_EN
                        state_nxt = S_CAP;
`else
                        state_nxt = S_REQ;
`endif
                    end
                end
            end

            S_HALT: begin
                if (start) begin
                    halted_nxt = 1'b0;
                    pc_nxt     = '0;
                    state_nxt  = S_REQ;
                end
            end

            default: begin
                state_nxt    = S_IDLE;
                ir_valid_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic
// checked against a transaction-level model of the delivered instruction stream.
`timescale 1ns/1ps
module tb_fetch_unit;

`ifdef FETCH_PREFETCH_EN
    localparam int PF = 1;
`else
    localparam int PF = 0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [10:0] imem_addr;
    logic [16:0] imem_data;
    logic [16:0] ir_out;
    logic        ir_valid;
    logic        ir_ready;
    logic        jump_en;
    logic [10:0] jump_target;
    logic [10:0] pc_out;
    logic        halted;

    logic [16:0] rom [2048];
    logic [10:0] exp_pc;
    int          n_tests = 0;
    int          n_fail  = 0;

    fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .imem_addr   (imem_addr),
        .imem_data   (imem_data),
        .ir_out      (ir_out),
        .ir_valid    (ir_valid),
        .ir_ready    (ir_ready),
        .jump_en     (jump_en),
        .jump_target (jump_target),
        .pc_out      (pc_out),
        .halted      (halted)
    );

    always #5 clk = ~clk;

    // Registered ROM: data for an address appears one cycle later.
    always @(posedge clk) imem_data <= rom[imem_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Wait for the next delivered instruction and compare it with the model.
    task automatic wait_valid(input int exp_lat, input bit noise);
        int n;
        n = 0;
        while (!ir_valid && n < 8) begin
            if (noise) begin
                start       = 1'($urandom);
                jump_en     = 1'($urandom);
                jump_target = 11'($urandom);
            end
            @(posedge clk); #1;
            n++;
        end
        start = 1'b0;
        check("latency", n, exp_lat);
        check("ir_out", ir_out, rom[exp_pc]);
        check("pc_out", pc_out, exp_pc);
        check("halted_clear", halted, 0);
    endtask

    task automatic accept(input bit jmp, input logic [10:0] tgt, output int lat, output bit went_halt);
        logic [16:0] ins;
        ins         = rom[exp_pc];
        start       = 1'b0;
        ir_ready    = 1'b1;
        jump_en     = jmp;
        jump_target = tgt;
        @(posedge clk); #1;
        ir_ready = 1'b0;
        jump_en  = 1'b0;
        check("valid_drop", ir_valid, 0);
        lat = 0;
        if (ins[16:12] == 5'd31) begin
            went_halt = 1'b1;
            check("halted_set", halted, 1);
        end else begin
            went_halt = 1'b0;
            check("halted_clear", halted, 0);
            exp_pc = jmp ? tgt : exp_pc + 11'd1;
            lat    = (jmp || PF == 0) ? 2 : 1;
        end
    endtask

    task automatic halt_restart();
        for (int i = 0; i < 10; i++) begin
            jump_en     = 1'($urandom);
            jump_target = 11'($urandom);
            @(posedge clk); #1;
            check("halt_hold", {halted, ir_valid}, 2'b10);
            check("pc_frozen", imem_addr, exp_pc);
        end
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("restart_halted", halted, 0);
        exp_pc = 11'd0;
        wait_valid(2, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int  lat;
        bit  h;
        bit  jmp;
        logic [10:0] tgt;

        for (int a = 0; a < 2048; a++)
            rom[a] = {5'($urandom_range(0, 30)), 12'($urandom)};
        rom[0]  = 17'h1E000;
        rom[1]  = 17'h0B000;
        rom[31] = 17'h18000;
        rom[58] = 17'h1F000;

        rst_n = 1'b0; start = 1'b0; ir_ready = 1'b0; jump_en = 1'b0; jump_target = '0;
        exp_pc = '0;

        // Reset held with start toggling
        for (int i = 0; i < 4; i++) begin
            start = 1'($urandom);
            @(posedge clk); #1;
            check("rst_valid", ir_valid, 0);
            check("rst_halted", halted, 0);
            check("rst_addr", imem_addr, 0);
            check("rst_ir", ir_out, 0);
            check("rst_pc_out", pc_out, 0);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("idle_valid", ir_valid, 0);

        // Basic fetch
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        exp_pc = 11'd0;
        wait_valid(2, 1'b0);
        check("first_ir", ir_out, 17'h1E000);
        accept(1'b0, 11'd0, lat, h);
        wait_valid(lat, 1'b0);
        check("second_ir", ir_out, 17'h0B000);

        // Backpressure at pc 1
        for (int i = 0; i < 5; i++) begin
            jump_en = 1'($urandom); jump_target = 11'($urandom); start = 1'($urandom);
            @(posedge clk); #1;
            check("bp_valid", ir_valid, 1);
            check("bp_ir", ir_out, 17'h0B000);
            check("bp_pc", pc_out, 1);
        end
        accept(1'b0, 11'd0, lat, h);
        wait_valid(lat, 1'b0);
        check("bp_next_pc", pc_out, 2);

        // Jump to 31, then jump back to 0
        accept(1'b1, 11'd31, lat, h);
        wait_valid(lat, 1'b0);
        check("ir31", ir_out, 17'h18000);
        accept(1'b1, 11'd0, lat, h);
        wait_valid(lat, 1'b0);
        check("jump_pc0", pc_out, 0);

        // Halt on ENDOP at 58, jump ignored
        accept(1'b1, 11'd58, lat, h);
        wait_valid(lat, 1'b0);
        accept(1'b1, 11'd5, lat, h);
        check("endop_halt", h, 1);
        halt_restart();

        // PC wrap
        accept(1'b1, 11'd2047, lat, h);
        wait_valid(lat, 1'b0);
        accept(1'b0, 11'd0, lat, h);
        wait_valid(lat, 1'b0);
        check("wrap_pc", pc_out, 0);

        // Randomized traffic
        for (int it = 0; it < 300; it++) begin
            for (int d = $urandom_range(0, 3); d > 0; d--) begin
                jump_en = 1'($urandom); jump_target = 11'($urandom); start = 1'($urandom);
                @(posedge clk); #1;
                check("hold_valid", ir_valid, 1);
                check("hold_pc", pc_out, exp_pc);
            end
            jmp = ($urandom_range(0, 3) == 0);
            tgt = ($urandom_range(0, 9) == 0) ? 11'd58 : 11'($urandom);
            accept(jmp, tgt, lat, h);
            if (h) halt_restart();
            else   wait_valid(lat, 1'b1);
        end

        // Reset asserted while in CAP
        if (rom[exp_pc][16:12] == 5'd31) begin
            accept(1'b0, 11'd0, lat, h);
            halt_restart();
        end
        accept(1'b1, 11'd100, lat, h);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        check("cap_rst_valid", ir_valid, 0);
        check("cap_rst_ir", ir_out, 0);
        check("cap_rst_pc_out", pc_out, 0);
        check("cap_rst_addr", imem_addr, 0);
        check("cap_rst_halted", halted, 0);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            check("post_rst_valid", ir_valid, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction fetch stage directly upstream of the 2048 x 17-bit instruction ROM.
- Owns the program counter and drives the ROM address.
- Captures the ROM's registered (1-cycle) output into an instruction register (IR).
- Presents the IR to the control unit over a valid/ready handshake; handles taken jumps and halts on ENDOP.

Parameters:
ADDR_W, 11, PC / ROM address width (2048 words)
INSTR_W, 17, instruction width ({opcode, operand})
OP_W, 5, opcode field width, IR[INSTR_W-1 -: OP_W]
ENDOP, 5'd31, opcode that halts fetching

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  begin fetching from PC=0; honoured only in IDLE or HALT
imem_addr  out  ADDR_W  ROM address, to instr_mem addr
imem_data  in  INSTR_W  ROM data, from instr_mem instr_out (valid 1 cycle after address)
ir_out  out  INSTR_W  latched instruction
ir_valid  out  1  ir_out holds an instruction not yet accepted
ir_ready  in  1  control unit accepts ir_out
jump_en  in  1  taken jump; sampled only on handshake (ir_valid && ir_ready)
jump_target  in  ADDR_W  jump destination, sampled with jump_en
pc_out  out  ADDR_W  address of the instruction in ir_out
halted  out  1  ENDOP accepted; fetch stopped

Behaviour:
- States: IDLE, REQ, CAP, VALID, HALT.
- Reset (async, rst_n=0): state=IDLE, pc=0, imem_addr=0, ir_out=0, ir_valid=0, pc_out=0, halted=0. Applies mid-fetch; any in-flight ROM data is discarded.
- imem_addr = pc combinationally in all states except VALID (see optional feature).
- IDLE: start=1 -> pc=0, go to REQ.
- REQ: ROM samples imem_addr at this edge; go to CAP.
- CAP: load ir_out<=imem_data, pc_out<=pc, ir_valid<=1; go to VALID.
- Latency: start sampled at edge E -> ir_valid=1 after edge E+2.
- VALID:
  - ir_out, pc_out and ir_valid are held stable until handshake.
  - On handshake with opcode==ENDOP: ir_valid<=0, halted<=1, go to HALT; jump_en is ignored.
  - On handshake otherwise: ir_valid<=0; if jump_en, pc<=jump_target, else pc<=pc+1; go to REQ.
  - Sustained throughput without the optional feature: one instruction per 3 cycles.
- PC arithmetic: modulo 2^ADDR_W; pc=2047 increments to 0.
- HALT:
  - ir_valid=0, halted=1, pc frozen.
  - start=1 -> halted<=0, pc=0, go to REQ.
- start is ignored in REQ, CAP and VALID. jump_en/jump_target are ignored without a handshake.
- Simultaneous start and handshake cannot conflict: start is only legal in IDLE/HALT, where ir_valid=0.

Optional Feature:
- Macro: FETCH_PREFETCH_EN.
- Defined:
  - In VALID, imem_addr = pc+1 (wrapping), speculatively reading the next sequential word.
  - Non-jump, non-ENDOP handshake: pc<=pc+1 and go directly to CAP, skipping REQ. The ROM already registered word pc+1 during VALID (VALID always lasts at least one cycle). Sequential throughput becomes one instruction per 2 cycles.
  - Jump handshake: go to REQ as normal.
  - ENDOP handling is unchanged.
- Undefined: imem_addr = pc in VALID; behaviour exactly as above.

Test Plan:
- Reset: hold rst_n=0 with start toggling -> ir_valid=0, halted=0, imem_addr=0, ir_out=0. Assert rst_n=0 while in CAP -> outputs clear immediately (no clock needed); no ir_valid after release.
- Basic fetch:
  - Stimulus: ROM[0]=0x1E000 (clac), ROM[1]=0x0B000; pulse start at edge E; ir_ready=1.
  - Required: ir_valid=1 after E+2 with ir_out=0x1E000, pc_out=0. Next: ir_out=0x0B000, pc_out=1, arriving 3 cycles later (2 with FETCH_PREFETCH_EN).
- Backpressure: hold ir_ready=0 for 5 cycles at pc 1 -> ir_out=0x0B000, pc_out=1 and ir_valid=1 stable all 5 cycles; release -> pc advances to 2.
- Jump: at pc 31 (0x18000), handshake with jump_en=1, jump_target=0 -> next ir_out=ROM[0], pc_out=0; pc 32 never fetched. Same result with FETCH_PREFETCH_EN.
- Halt/restart:
  - Stimulus: ROM[58]=0x1F000; accept it with jump_en=1.
  - Required: halted=1 and ir_valid=0 the next cycle; pc frozen for 10 cycles. Then pulse start -> halted=0, ir_out=ROM[0], pc_out=0.
- Wrap: jump to 2047 holding a non-jump instruction; accept -> next pc_out=0, ir_out=ROM[0].
